// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART transmitter state encoding and framing constants.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int PAR_NONE   = 0;
   localparam int PAR_EVEN   = 1;
   localparam int PAR_ODD    = 2;
   localparam int OVERSAMPLE = 16;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo_drain
// Brief  : UART transmitter that pops the TX FIFO whenever non-empty and
//          serializes each word (start, LSB-first data, optional parity, stop).
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int PARITY  = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            fifo_empty,
   input  logic [DBIT-1:0] fifo_rdata,
   output logic            fifo_rd,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam logic [4:0] c_bit_last  = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] c_stop_last = 5'(SB_TICK - 1);
   localparam logic [2:0] c_n_last    = 3'(DBIT - 1);
   localparam logic       c_par_inv   = (PARITY == PAR_ODD);

   uart_state_e     r_state, w_state_nx;
   logic [4:0]      r_s, w_s_nx;
   logic [2:0]      r_n, w_n_nx;
   logic [DBIT-1:0] r_b, w_b_nx;
   logic            r_par, w_par_nx;
   logic            r_tx, w_tx_nx;
   logic            w_rd, w_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_s     <= w_s_nx;
         r_n     <= w_n_nx;
         r_b     <= w_b_nx;
         r_par   <= w_par_nx;
         r_tx    <= w_tx_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_s_nx     = r_s;
      w_n_nx     = r_n;
      w_b_nx     = r_b;
      w_par_nx   = r_par;
      w_rd       = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               w_rd       = 1'b1;
               w_b_nx     = fifo_rdata;
               w_par_nx   = (^fifo_rdata) ^ c_par_inv;
               w_s_nx     = '0;
               w_state_nx = ST_START;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (r_s == c_bit_last) begin
                  w_s_nx     = '0;
                  w_n_nx     = '0;
                  w_state_nx = ST_DATA;
               end else begin
                  w_s_nx = r_s + 5'd1;
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (r_s == c_bit_last) begin
                  w_s_nx = '0;
                  w_b_nx = r_b >> 1;
                  w_n_nx = r_n + 3'd1;
                  if (r_n == c_n_last)
                     w_state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  w_s_nx = r_s + 5'd1;
               end
            end
         end
         ST_PARITY: begin
            if (s_tick) begin
               if (r_s == c_bit_last) begin
                  w_s_nx     = '0;
                  w_state_nx = ST_STOP;
               end else begin
                  w_s_nx = r_s + 5'd1;
               end
            end
         end
         ST_STOP: begin
            if (s_tick) begin
               if (r_s == c_stop_last) begin
                  w_done     = 1'b1;
                  w_state_nx = ST_IDLE;
               end else begin
                  w_s_nx = r_s + 5'd1;
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase

      // tx is registered from the next state so the line changes with the state
      case (w_state_nx)
         ST_START:  w_tx_nx = 1'b0;
         ST_DATA:   w_tx_nx = w_b_nx[0];
         ST_PARITY: w_tx_nx = w_par_nx;
         default:   w_tx_nx = 1'b1;
      endcase
   end

   assign fifo_rd      = w_rd & ~reset;
   assign tx_done_tick = w_done & ~reset;
   assign tx           = r_tx;
   assign tx_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_fifo_drain
// Brief  : Directed scoreboard bench for four uart_tx_fifo_drain configurations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

   typedef struct {
      logic [10:0] bits;
      int          nb;
      int          stop_ticks;
   } frame_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_tick = 1'b0;
   logic       fe [4];
   logic [7:0] fd [4];
   logic       rd [4];
   logic       tx [4];
   logic       busy [4];
   logic       done [4];

   frame_t     exp_q[$];
   logic [7:0] fq[$];
   int         sel = 0;
   int         rd_cnt [4] = '{default: 0};
   logic       rd_bad = 1'b0;
   int         total = 0;
   int         passes = 0;
   int         fails = 0;

   // u0: no parity, u1: even, u2: odd, u3: no parity with two stop bits
   uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fe[0]), .fifo_rdata(fd[0]),
      .fifo_rd(rd[0]), .tx(tx[0]), .tx_busy(busy[0]), .tx_done_tick(done[0]));
   uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fe[1]), .fifo_rdata(fd[1]),
      .fifo_rd(rd[1]), .tx(tx[1]), .tx_busy(busy[1]), .tx_done_tick(done[1]));
   uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fe[2]), .fifo_rdata(fd[2]),
      .fifo_rd(rd[2]), .tx(tx[2]), .tx_busy(busy[2]), .tx_done_tick(done[2]));
   uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u3 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fe[3]), .fifo_rdata(fd[3]),
      .fifo_rd(rd[3]), .tx(tx[3]), .tx_busy(busy[3]), .tx_done_tick(done[3]));

   always #5 clk = ~clk;

   initial begin : g_tick
      int c;
      c = 0;
      forever begin
         @(posedge clk);
         #1;
         c = (c + 1) % 3;
         s_tick = (c == 0);
      end
   end

   // FIFO model: only the selected instance sees data; pops on fifo_rd
   initial begin : g_fifo
      logic pop;
      for (int i = 0; i < 4; i++) begin
         fe[i] = 1'b1;
         fd[i] = 8'h00;
      end
      forever begin
         @(negedge clk);
         pop = rd[sel];
         for (int i = 0; i < 4; i++) begin
            if (rd[i] === 1'b1) begin
               rd_cnt[i]++;
               if (i != sel || fq.size() == 0) rd_bad = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         if (pop === 1'b1 && fq.size() > 0) void'(fq.pop_front());
         for (int i = 0; i < 4; i++) begin
            fe[i] = !(i == sel && fq.size() != 0);
            fd[i] = (i == sel && fq.size() != 0) ? fq[0] : 8'h00;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input int idx, input logic [7:0] d, input bit track);
      frame_t f;
      fq.push_back(d);
      f.bits       = '1;
      f.bits[0]    = 1'b0;
      f.bits[8:1]  = d;
      f.nb         = 10;
      f.stop_ticks = (idx == 3) ? 32 : 16;
      if (idx == 1 || idx == 2) begin
         f.bits[9] = (idx == 1) ? (^d) : ~(^d);
         f.nb      = 11;
      end
      if (track) exp_q.push_back(f);
   endtask

   // Ends on the first negedge after the frame's final tick
   task automatic check_frame(input int idx, input string tag, output int wcyc);
      frame_t f;
      int     need;
      int     t;
      logic   bad;
      logic   done_ok;
      f    = exp_q.pop_front();
      wcyc = 0;
      do begin
         @(negedge clk);
         wcyc++;
      end while (tx[idx] !== 1'b0 && wcyc < 3000);
      chk({tag, "_start"}, {31'd0, tx[idx]}, 32'd0);
      if (tx[idx] !== 1'b0) return;
      for (int k = 0; k < f.nb; k++) begin
         need    = (k == f.nb - 1) ? f.stop_ticks : 16;
         t       = 0;
         bad     = 1'b0;
         done_ok = 1'b0;
         while (t < need) begin
            if (tx[idx] !== f.bits[k] || busy[idx] !== 1'b1) bad = 1'b1;
            if (s_tick) t++;
            if (done[idx] !== 1'b0) begin
               if (k == f.nb - 1 && t == need && s_tick) done_ok = 1'b1;
               else bad = 1'b1;
            end
            if (t < need) @(negedge clk);
         end
         chk($sformatf("%s_bit%0d", tag, k), {31'd0, bad}, 32'd0);
         if (k == f.nb - 1) chk({tag, "_done"}, {31'd0, done_ok}, 32'd1);
         @(negedge clk);
      end
   endtask

   initial begin : g_main
      int   w;
      int   c0;
      int   t;
      logic bad;

      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx[0]}, 32'd1);
      chk("rst_rd", {31'd0, rd[0]}, 32'd0);
      chk("rst_busy", {31'd0, busy[0]}, 32'd0);
      chk("rst_done", {31'd0, done[0]}, 32'd0);
      reset = 1'b0;

      bad = 1'b0;
      repeat (100) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++)
            if ({tx[i], rd[i], busy[i], done[i]} !== 4'b1000) bad = 1'b1;
      end
      chk("idle_100", {31'd0, bad}, 32'd0);

      c0 = rd_cnt[0];
      push_word(0, 8'hA5, 1'b1);
      check_frame(0, "a5", w);
      chk("a5_busy_fall", {31'd0, busy[0]}, 32'd0);
      chk("a5_tx_idle", {31'd0, tx[0]}, 32'd1);
      repeat (5) @(negedge clk);
      chk("a5_rd_cnt", 32'(rd_cnt[0] - c0), 32'd1);

      c0 = rd_cnt[0];
      push_word(0, 8'h01, 1'b1);
      push_word(0, 8'hFF, 1'b1);
      check_frame(0, "b2b1", w);
      check_frame(0, "b2b2", w);
      chk("b2b_gap", 32'(w), 32'd1);
      repeat (5) @(negedge clk);
      chk("b2b_rd_cnt", 32'(rd_cnt[0] - c0), 32'd2);

      sel = 1;
      repeat (3) @(negedge clk);
      push_word(1, 8'h07, 1'b1);
      check_frame(1, "even07", w);
      sel = 2;
      repeat (3) @(negedge clk);
      push_word(2, 8'h07, 1'b1);
      check_frame(2, "odd07", w);

      sel = 0;
      repeat (3) @(negedge clk);
      c0 = rd_cnt[0];
      push_word(0, 8'h3C, 1'b0);
      push_word(0, 8'h5A, 1'b1);
      w = 0;
      while (tx[0] !== 1'b0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      t = 0;
      while (t < 56) begin
         @(negedge clk);
         if (s_tick) t++;
      end
      chk("abort_busy_mid", {31'd0, busy[0]}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_tx", {31'd0, tx[0]}, 32'd1);
      chk("abort_busy", {31'd0, busy[0]}, 32'd0);
      chk("abort_rd", {31'd0, rd[0]}, 32'd0);
      reset = 1'b0;
      check_frame(0, "fresh5a", w);
      repeat (5) @(negedge clk);
      chk("abort_rd_cnt", 32'(rd_cnt[0] - c0), 32'd2);

      sel = 3;
      repeat (3) @(negedge clk);
      push_word(3, 8'hC3, 1'b1);
      check_frame(3, "sb32", w);
      chk("sb32_busy_fall", {31'd0, busy[3]}, 32'd0);

      repeat (5) @(negedge clk);
      chk("rd_when_empty", {31'd0, rd_bad}, 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
`default_nettype wire
